// File: rtl/branch_redirect_ctrl.sv
// IF-stage next-PC redirect producer: turns EX branch resolutions into a
// redirect that lands on the fetch after the delay slot, with flush priority.
module branch_redirect_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter bit          DS_ENABLE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ex_branch_valid_i,
  input  logic              ex_branch_taken_i,
  input  logic [ADDR_W-1:0] ex_branch_pc_i,
  input  logic [ADDR_W-1:0] ex_branch_target_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic              if_fetch_ack_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_addr_i,
  output logic              branch_flag_o,
  output logic [ADDR_W-1:0] branch_to_addr_o,
  output logic              squash_o,
  output logic              ex_stall_o,
  output logic              target_misaligned_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DS  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q;
  logic [ADDR_W-1:0] ds_q;
  logic [ADDR_W-1:0] ds_next_pc;
  logic              accept;
  logic              squash_d;
  logic              flag_d;
  logic [ADDR_W-1:0] addr_d;

  assign ex_stall_o = ex_branch_valid_i && (state_q != IDLE);
  assign accept     = ex_branch_valid_i && ex_branch_taken_i && !ex_stall_o && !flush_i;
  assign ds_next_pc = ds_q + ADDR_W'(4);

  always_comb begin
    state_d  = state_q;
    flag_d   = 1'b0;
    addr_d   = '0;
    squash_d = 1'b0;
    if (flush_i) begin
      flag_d  = 1'b1;
      addr_d  = flush_addr_i;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) state_d = DS_ENABLE ? WAIT_DS : REDIRECT;
        end
        WAIT_DS: begin
          if (if_pc_i == ds_q) begin
            flag_d = 1'b1;
            addr_d = tgt_q;
            if (if_fetch_ack_i) state_d = IDLE;
          end else if (if_pc_i == ds_next_pc) begin
            // IF already ran past the delay slot: kill that fetch, then redirect
            state_d  = REDIRECT;
            squash_d = 1'b1;
          end
        end
        REDIRECT: begin
          flag_d = 1'b1;
          addr_d = tgt_q;
          if (if_fetch_ack_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reset also masks the combinational flush path so the flag is low throughout reset
  assign branch_flag_o    = flag_d && rst_i;
  assign branch_to_addr_o = rst_i ? addr_d : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q             <= IDLE;
      tgt_q               <= '0;
      ds_q                <= '0;
      squash_o            <= 1'b0;
      target_misaligned_o <= 1'b0;
    end else begin
      state_q             <= state_d;
      squash_o            <= squash_d;
      target_misaligned_o <= accept && (ex_branch_target_i[1:0] != 2'b00);
      if (accept) begin
        tgt_q <= ex_branch_target_i;
        ds_q  <= ex_branch_pc_i + ADDR_W'(4);
      end
    end
  end

endmodule
